regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between NREQ writeback sources (ALU, load unit, ...).

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/wb_rr_arbiter.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 72 +++++++
 tb/tb_regfile_wb_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and helpers for the register-file writeback arbiter.
// XLEN/REG_AW set the default data and register-address widths.
package regfile_wb_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // k-th candidate in round-robin order after the last winner
  function automatic int rr_next(input int last, input int k, input int n);
    return (last + 1 + k) % n;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, search starts after the last winner.
// The grant is combinational; only the rr_last pointer is registered.
module wb_rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] rr_last;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_next(int'(rr_last), k, NREQ);
      if (!found && !rst && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= PW'(NREQ - 1);
    end else if (found) begin
      rr_last <= grant_idx;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NREQ writeback sources; winner is staged one cycle.
// Optional macro WB_BYPASS_EN adds two read-side compare ports against the staged write.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = XLEN,
  parameter int AW   = REG_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_rd,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic               rf_we,
  output logic [AW-1:0]      rf_rd,
  output logic [DW-1:0]      rf_wdata,
  output logic               busy
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0]      byp_rs1,
  input  logic [AW-1:0]      byp_rs2,
  output logic               byp_hit1,
  output logic               byp_hit2,
  output logic [DW-1:0]      byp_data1,
  output logic [DW-1:0]      byp_data2
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] grant_idx;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_wdata;

  wb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .grant     (req_ready),
    .grant_idx (grant_idx)
  );

  assign sel_rd    = req_rd[int'(grant_idx)*AW +: AW];
  assign sel_wdata = req_wdata[int'(grant_idx)*DW +: DW];

  // x0 targets still complete the handshake; only the write enable is suppressed
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (|req_ready) begin
      rf_we    <= (sel_rd != AW'(REG_ZERO));
      rf_rd    <= sel_rd;
      rf_wdata <= sel_wdata;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign busy = rf_we;

`ifdef WB_BYPASS_EN
  assign byp_hit1  = rf_we && (byp_rs1 == rf_rd) && (byp_rs1 != AW'(REG_ZERO));
  assign byp_hit2  = rf_we && (byp_rs2 == rf_rd) && (byp_rs2 != AW'(REG_ZERO));
  assign byp_data1 = byp_hit1 ? rf_wdata : '0;
  assign byp_data2 = byp_hit2 ? rf_wdata : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=2); bypass checks only when WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_wdata;
  logic               rf_we;
  logic [AW-1:0]      rf_rd;
  logic [DW-1:0]      rf_wdata;
  logic               busy;
`ifdef WB_BYPASS_EN
  logic [AW-1:0]      byp_rs1;
  logic [AW-1:0]      byp_rs2;
  logic               byp_hit1;
  logic               byp_hit2;
  logic [DW-1:0]      byp_data1;
  logic [DW-1:0]      byp_data2;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_wdata (req_wdata),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
`ifdef WB_BYPASS_EN
    ,
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp_hit1  (byp_hit1),
    .byp_hit2  (byp_hit2),
    .byp_data1 (byp_data1),
    .byp_data2 (byp_data2)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_rd    = {r1, r0};
    req_wdata = {d1, d0};
  endtask

  // advance to just after the next rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(2'b11, 5'd3, 5'd4, 32'h1, 32'h2);
`ifdef WB_BYPASS_EN
    byp_rs1 = '0;
    byp_rs2 = '0;
`endif
    #1;
    chk("rst_ready", 64'(req_ready), 64'(2'b00));
    tick;
    tick;
    chk("rst_we",   64'(rf_we), 64'(1'b0));
    chk("rst_rd",   64'(rf_rd), 64'(5'd0));
    chk("rst_busy", 64'(busy),  64'(1'b0));
    chk("rst_ready2", 64'(req_ready), 64'(2'b00));
    rst = 1'b0;

    // single request from req0
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    #1;
    chk("single_ready", 64'(req_ready), 64'(2'b01));
    tick;
    chk("single_we",    64'(rf_we),    64'(1'b1));
    chk("single_rd",    64'(rf_rd),    64'(5'd5));
    chk("single_wdata", 64'(rf_wdata), 64'(32'hDEADBEEF));
    chk("single_busy",  64'(busy),     64'(1'b1));
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    #1;
    chk("idle_ready", 64'(req_ready), 64'(2'b00));
    tick;
    chk("idle_we", 64'(rf_we), 64'(1'b0));
    chk("idle_rd_hold", 64'(rf_rd), 64'(5'd5));
    chk("idle_wdata_hold", 64'(rf_wdata), 64'(32'hDEADBEEF));

    // x0 write from req1: handshake but no write, pointer moves to 1
    drive(2'b10, 5'd0, 5'd0, 32'h0, 32'h1234);
    #1;
    chk("x0_ready", 64'(req_ready), 64'(2'b10));
    tick;
    chk("x0_we",   64'(rf_we), 64'(1'b0));
    chk("x0_busy", 64'(busy),  64'(1'b0));

    // contention: alternate 0,1,0,1 starting with req0
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 5'd1, 5'd2, 32'h11111111, 32'h22222222);
      #1;
      chk($sformatf("cont_ready%0d", i), 64'(req_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick;
      chk($sformatf("cont_rd%0d", i), 64'(rf_rd), (i % 2 == 0) ? 64'(5'd1) : 64'(5'd2));
      chk($sformatf("cont_wdata%0d", i), 64'(rf_wdata),
          (i % 2 == 0) ? 64'(32'h11111111) : 64'(32'h22222222));
      chk($sformatf("cont_we%0d", i), 64'(rf_we), 64'(1'b1));
    end

    // reset mid-operation: pointer sits at 0 after the grant, reset must restore req0 priority
    drive(2'b01, 5'd7, 5'd8, 32'h77, 32'h88);
    #1;
    chk("mid_ready", 64'(req_ready), 64'(2'b01));
    tick;
    chk("mid_we", 64'(rf_we), 64'(1'b1));
    chk("mid_rd", 64'(rf_rd), 64'(5'd7));
    rst = 1'b1;
    drive(2'b11, 5'd7, 5'd8, 32'h77, 32'h88);
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(2'b00));
    tick;
    chk("mid_rst_we", 64'(rf_we), 64'(1'b0));
    chk("mid_rst_rd", 64'(rf_rd), 64'(5'd0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'(2'b01));
    tick;
    chk("post_rst_rd", 64'(rf_rd), 64'(5'd7));
    chk("post_rst_we", 64'(rf_we), 64'(1'b1));

`ifdef WB_BYPASS_EN
    drive(2'b01, 5'd9, 5'd0, 32'hA5A5A5A5, 32'h0);
    tick;
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    byp_rs1 = 5'd9;
    byp_rs2 = 5'd0;
    #1;
    chk("byp_hit1",  64'(byp_hit1),  64'(1'b1));
    chk("byp_data1", 64'(byp_data1), 64'(32'hA5A5A5A5));
    chk("byp_hit2",  64'(byp_hit2),  64'(1'b0));
    chk("byp_data2", 64'(byp_data2), 64'(32'h0));
    byp_rs1 = 5'd3;
    #1;
    chk("byp_miss1", 64'(byp_hit1), 64'(1'b0));
`endif

    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
